// File: rtl/ro_meas_pkg.sv
// Shared types and helpers for the ring-oscillator measurement sequencer.
// The next-RO search works on a 16-bit mask, the largest bank size supported.
package ro_meas_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCount,
        StReport,
        StFinish
    } state_e;

    localparam int unsigned MaxRo = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } ro_pick_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Lowest set mask bit at or above index 'from'.
    function automatic ro_pick_t next_ro(input logic [MaxRo-1:0] mask, input int unsigned from);
        ro_pick_t pick;
        pick = '0;
        for (int i = MaxRo - 1; i >= 0; i--) begin
            if (i >= int'(from) && mask[i]) begin
                pick.found = 1'b1;
                pick.idx   = 4'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronizes one asynchronous RO output and emits a one-cycle pulse per rising edge.
// Input-to-pulse latency is SYNC_STAGES+1 cycles.
module ro_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic ro_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic                   pulse_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ro_in};
            sync_d_q <= sync_q[SYNC_STAGES-1];
            pulse_q  <= sync_q[SYNC_STAGES-1] & ~sync_d_q;
        end
    end

    assign edge_pulse = pulse_q;

endmodule

// File: rtl/ro_meas_sequencer.sv
// Sweeps the unmasked ring oscillators one at a time: enable, settle, count edges
// over a fixed window, report. Only one RO is ever enabled.
module ro_meas_sequencer
    import ro_meas_pkg::*;
#(
    parameter int unsigned N_RO          = 4,
    parameter int unsigned WIN_CYCLES    = 1024,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Start,
    input  logic                     i_Abort,
    input  logic [N_RO-1:0]          i_RO_mask,
    input  logic [N_RO-1:0]          i_RO_out,
    output logic [N_RO-1:0]          o_RO_enable,
    output logic [N_RO-1:0]          o_RO_sel,
    output logic                     o_Busy,
    output logic                     o_Valid,
    output logic [CNT_W-1:0]         o_Count,
    output logic [clog2(N_RO)-1:0]   o_RO_idx,
    output logic                     o_Overflow,
    output logic                     o_Done
);

    localparam int unsigned IdxW = clog2(N_RO);
    localparam int unsigned WinW = clog2(WIN_CYCLES + 1);
    localparam int unsigned SetW = clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [WinW-1:0]  WinLast    = WinW'(WIN_CYCLES - 1);
    localparam logic [SetW-1:0]  SettleLast = SetW'(SETTLE_CYCLES - 1);
    localparam logic [N_RO-1:0]  OneLsb     = N_RO'(1);

    state_e            state_q;
    logic [N_RO-1:0]   mask_q;
    logic [IdxW-1:0]   idx_q;
    logic [SetW-1:0]   settle_q;
    logic [WinW-1:0]   win_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [N_RO-1:0]   enable_q;
    logic              busy_q;
    logic              valid_q;
    logic [CNT_W-1:0]  count_q;
    logic [IdxW-1:0]   ro_idx_q;
    logic              overflow_q;
    logic              done_q;

    logic [MaxRo-1:0]  start_mask;
    logic [MaxRo-1:0]  held_mask;
    ro_pick_t          first_pick;
    ro_pick_t          later_pick;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf_next;
    logic              edge_pulse;
    logic              sync_clear;

    // History is flushed whenever no RO is being measured, so each RO starts clean.
    assign sync_clear = (state_q != StSettle) && (state_q != StCount);

    ro_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk       (i_Clk),
        .rst       (i_Rst),
        .clear     (sync_clear),
        .ro_in     (i_RO_out[idx_q]),
        .edge_pulse(edge_pulse)
    );

    always_comb begin
        start_mask             = '0;
        start_mask[N_RO-1:0]   = i_RO_mask;
        held_mask              = '0;
        held_mask[N_RO-1:0]    = mask_q;
        first_pick             = next_ro(start_mask, 0);
        later_pick             = next_ro(held_mask, 32'(idx_q) + 32'd1);
    end

    always_comb begin
        cnt_next = cnt_q;
        ovf_next = ovf_q;
        if (edge_pulse) begin
            if (cnt_q == CntMax) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            idx_q      <= '0;
            settle_q   <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            enable_q   <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            ro_idx_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (i_Abort && state_q != StIdle && state_q != StFinish) begin
                state_q  <= StFinish;
                enable_q <= '0;
                done_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (i_Start && !i_Abort) begin
                            mask_q <= i_RO_mask;
                            busy_q <= 1'b1;
                            if (first_pick.found) begin
                                state_q  <= StSettle;
                                idx_q    <= IdxW'(first_pick.idx);
                                enable_q <= OneLsb << first_pick.idx;
                                settle_q <= '0;
                            end else begin
                                state_q <= StFinish;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    StSettle: begin
                        if (settle_q == SettleLast) begin
                            state_q <= StCount;
                            win_q   <= '0;
                            cnt_q   <= '0;
                            ovf_q   <= 1'b0;
                        end else begin
                            settle_q <= settle_q + 1'b1;
                        end
                    end
                    StCount: begin
                        cnt_q <= cnt_next;
                        ovf_q <= ovf_next;
                        win_q <= win_q + 1'b1;
                        if (win_q == WinLast) begin
                            state_q    <= StReport;
                            enable_q   <= '0;
                            valid_q    <= 1'b1;
                            count_q    <= cnt_next;
                            overflow_q <= ovf_next;
                            ro_idx_q   <= idx_q;
                        end
                    end
                    StReport: begin
                        if (later_pick.found) begin
                            state_q  <= StSettle;
                            idx_q    <= IdxW'(later_pick.idx);
                            enable_q <= OneLsb << later_pick.idx;
                            settle_q <= '0;
                        end else begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end
                    end
                    StFinish: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_RO_enable = enable_q;
    assign o_RO_sel    = enable_q;
    assign o_Busy      = busy_q;
    assign o_Valid     = valid_q;
    assign o_Count     = count_q;
    assign o_RO_idx    = ro_idx_q;
    assign o_Overflow  = overflow_q;
    assign o_Done      = done_q;

endmodule
